alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 8, the operand and result width; legal range 4..32.
REQ-002 SHALL take parameter SEL_WIDTH, default 4, the opcode width; values below 4 are illegal.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have ports: operand1, operand2  input  DATA_WIDTH each  operands, captured on accept.
REQ-007 SHALL have port: opCode  input  SEL_WIDTH  operation select, captured on accept.
REQ-008 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking valid results.
REQ-010 SHALL have ports: result, resultHigh  output  DATA_WIDTH each  low and high result words.
REQ-011 SHALL have ports: carryOut, zero, overflow, divByZero  output  1 each  status flags.

Function
REQ-012 Accept SHALL occur at a rising edge where state=IDLE and start=1; operands and opCode SHALL be registered then; start while busy SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, CALC, DONE; DONE SHALL last exactly one cycle and return to IDLE; done=1 only in DONE.
REQ-014 Opcodes 0-8 (single-cycle) and 11-15 SHALL go IDLE->DONE: done high in the cycle after accept (latency 1).
REQ-015 Opcodes 9, 10 SHALL go IDLE->CALC for DATA_WIDTH cycles, then DONE: done high DATA_WIDTH+1 cycles after accept.
REQ-016 Opcode map: 0 ADD, 1 SUB (op1-op2), 2 AND, 3 OR, 4 XOR, 5 NOT op1, 6 SHL, 7 SHR logical, 8 SRA; shift amount = operand2 mod DATA_WIDTH.
REQ-017 Opcode 9 MUL SHALL be unsigned iterative shift-add, one bit per CALC cycle; {resultHigh,result} = 2*DATA_WIDTH-bit product.
REQ-018 Opcode 10 DIV SHALL be unsigned restoring division, one bit per CALC cycle; result=quotient, resultHigh=remainder.
REQ-019 DIV with operand2=0 SHALL skip CALC (latency 1): result all ones, resultHigh=operand1, divByZero=1.
REQ-020 Opcodes 11-15 SHALL yield result=0, resultHigh=0, all flags 0 except zero=1.
REQ-021 resultHigh SHALL be 0 for every opcode except 9 and 10.
REQ-022 carryOut: ADD carry out of MSB; SUB borrow (1 iff op1<op2 unsigned); SHL/SHR/SRA last bit shifted out (0 for shift by 0); others 0.
REQ-023 overflow: ADD/SUB signed two's-complement overflow; MUL 1 iff resultHigh!=0; others 0.
REQ-024 zero SHALL be 1 iff result=0 and resultHigh=0.
REQ-025 Outputs and flags SHALL update only on entry to DONE and hold until the next DONE; they SHALL NOT show intermediate CALC values.
REQ-026 A new start SHALL be acceptable in the cycle immediately after DONE (back-to-back throughput 1 op per 2 cycles for single-cycle ops).

Reset
REQ-027 reset=1 SHALL asynchronously force state=IDLE, busy=0, done=0, result=0, resultHigh=0, all flags 0, iteration counter 0.
REQ-028 Reset during CALC SHALL abandon the operation; no done pulse SHALL follow after reset deasserts.
REQ-029 First accept SHALL be possible at the first rising edge after reset deasserts.

Verification (DATA_WIDTH=8)
REQ-030 ADD 0xFF+0x01 -> done 1 cycle after accept; result=0x00, carryOut=1, zero=1, overflow=0.
REQ-031 SUB 0x80-0x01 -> result=0x7F, overflow=1, carryOut=0; SUB 0x01-0x02 -> result=0xFF, carryOut=1.
REQ-032 MUL 0xFF*0xFF -> done 9 cycles after accept; result=0x01, resultHigh=0xFE, overflow=1; start pulsed during CALC ignored, busy=1 throughout.
REQ-033 DIV 200/7 -> done 9 cycles after accept, result=28, resultHigh=4; DIV 0x55/0 -> done after 1 cycle, result=0xFF, resultHigh=0x55, divByZero=1.
REQ-034 SRA 0x81 by 1 -> result=0xC0, carryOut=1; SHL by operand2=9 -> shift by 1.
REQ-035 reset asserted at CALC cycle 4 of MUL -> all outputs 0 immediately, no done pulse; a fresh ADD accepted next edge after deassert completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential ALU with single-cycle logic/arith/shift operations and
// iterative (one bit per cycle) unsigned multiply and restoring divide.
//
// Ports
//   clk                 : rising-edge clock
//   reset               : asynchronous active-high reset
//   start               : operation request, sampled only while idle
//   operand1, operand2  : DATA_WIDTH operands, captured on accept
//   opCode              : SEL_WIDTH operation select, captured on accept
//   busy                : high whenever the FSM is not idle
//   done                : one-cycle pulse, results valid
//   result, resultHigh  : low / high result words
//   carryOut, zero, overflow, divByZero : status flags
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] operand1,
   input  logic [DATA_WIDTH-1:0] operand2,
   input  logic [SEL_WIDTH-1:0]  opCode,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic [DATA_WIDTH-1:0] resultHigh,
   output logic                  carryOut,
   output logic                  zero,
   output logic                  overflow,
   output logic                  divByZero
);

   localparam int W  = DATA_WIDTH;
   localparam int SW = $clog2(DATA_WIDTH);
   localparam int CW = $clog2(DATA_WIDTH);

   localparam logic [SEL_WIDTH-1:0] OP_ADD = SEL_WIDTH'(4'd0);
   localparam logic [SEL_WIDTH-1:0] OP_SUB = SEL_WIDTH'(4'd1);
   localparam logic [SEL_WIDTH-1:0] OP_AND = SEL_WIDTH'(4'd2);
   localparam logic [SEL_WIDTH-1:0] OP_OR  = SEL_WIDTH'(4'd3);
   localparam logic [SEL_WIDTH-1:0] OP_XOR = SEL_WIDTH'(4'd4);
   localparam logic [SEL_WIDTH-1:0] OP_NOT = SEL_WIDTH'(4'd5);
   localparam logic [SEL_WIDTH-1:0] OP_SHL = SEL_WIDTH'(4'd6);
   localparam logic [SEL_WIDTH-1:0] OP_SHR = SEL_WIDTH'(4'd7);
   localparam logic [SEL_WIDTH-1:0] OP_SRA = SEL_WIDTH'(4'd8);
   localparam logic [SEL_WIDTH-1:0] OP_MUL = SEL_WIDTH'(4'd9);
   localparam logic [SEL_WIDTH-1:0] OP_DIV = SEL_WIDTH'(4'd10);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [2*W-1:0]       work_q, work_d;     // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
   logic [W-1:0]         op2_q, op2_d;
   logic [SEL_WIDTH-1:0] opc_q, opc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [W-1:0]         res_q, res_d, hi_q, hi_d;
   logic                 carry_q, carry_d, zero_q, zero_d;
   logic                 ovf_q, ovf_d, dbz_q, dbz_d;

   // Single-cycle datapath, evaluated directly on the live inputs at accept.
   logic [SW-1:0]        shamt_s;
   logic [W:0]           add_s, sub_s, shl_s, shr_s, sra_s;
   logic signed [W:0]    sra_in_s;
   logic [W-1:0]         alu_res_s, alu_hi_s;
   logic                 alu_c_s, alu_v_s, alu_dbz_s;

   assign shamt_s  = SW'(32'(operand2) % DATA_WIDTH);
   assign add_s    = {1'b0, operand1} + {1'b0, operand2};
   assign sub_s    = {1'b0, operand1} - {1'b0, operand2};
   // Shifts run one bit wider so the last bit shifted out lands in a fixed slot.
   assign shl_s    = {1'b0, operand1} << shamt_s;
   assign shr_s    = {operand1, 1'b0} >> shamt_s;
   assign sra_in_s = {operand1, 1'b0};
   assign sra_s    = sra_in_s >>> shamt_s;

   // Iteration step datapaths.
   logic [W:0]     mul_sum_s, div_shift_s, div_sub_s;
   logic           div_ge_s;
   logic [2*W-1:0] mul_next_s, div_next_s;

   assign mul_sum_s   = {1'b0, work_q[2*W-1:W]} +
                        (work_q[0] ? {1'b0, op2_q} : {(W+1){1'b0}});
   assign mul_next_s  = {mul_sum_s, work_q[W-1:1]};
   assign div_shift_s = {work_q[2*W-1:W], work_q[W-1]};
   assign div_ge_s    = (div_shift_s >= {1'b0, op2_q});
   assign div_sub_s   = div_shift_s - {1'b0, op2_q};
   assign div_next_s  = div_ge_s ? {div_sub_s[W-1:0],   work_q[W-2:0], 1'b1}
                                 : {div_shift_s[W-1:0], work_q[W-2:0], 1'b0};

   // Single-cycle operation results and flags.
   always_comb begin
      alu_res_s = '0;
      alu_hi_s  = '0;
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      alu_dbz_s = 1'b0;
      case (opCode)
         OP_ADD: begin
            alu_res_s = add_s[W-1:0];
            alu_c_s   = add_s[W];
            alu_v_s   = (operand1[W-1] == operand2[W-1]) && (add_s[W-1] != operand1[W-1]);
         end
         OP_SUB: begin
            alu_res_s = sub_s[W-1:0];
            alu_c_s   = sub_s[W];
            alu_v_s   = (operand1[W-1] != operand2[W-1]) && (sub_s[W-1] != operand1[W-1]);
         end
         OP_AND: alu_res_s = operand1 & operand2;
         OP_OR:  alu_res_s = operand1 | operand2;
         OP_XOR: alu_res_s = operand1 ^ operand2;
         OP_NOT: alu_res_s = ~operand1;
         OP_SHL: begin
            alu_res_s = shl_s[W-1:0];
            alu_c_s   = shl_s[W];
         end
         OP_SHR: begin
            alu_res_s = shr_s[W:1];
            alu_c_s   = shr_s[0];
         end
         OP_SRA: begin
            alu_res_s = sra_s[W:1];
            alu_c_s   = sra_s[0];
         end
         OP_DIV: begin
            // Only the divide-by-zero case completes in a single cycle.
            if (operand2 == '0) begin
               alu_res_s = '1;
               alu_hi_s  = operand1;
               alu_dbz_s = 1'b1;
            end else begin
               alu_dbz_s = 1'b0;
            end
         end
         default: alu_res_s = '0;   // MUL handled iteratively; reserved codes give zero
      endcase
   end

   // Next-state, iteration and output-register update logic.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      op2_d   = op2_q;
      opc_d   = opc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      hi_d    = hi_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op2_d = operand2;
               opc_d = opCode;
               if ((opCode == OP_MUL) || ((opCode == OP_DIV) && (operand2 != '0))) begin
                  work_d  = {{W{1'b0}}, operand1};
                  cnt_d   = '0;
                  state_d = S_CALC;
               end else begin
                  res_d   = alu_res_s;
                  hi_d    = alu_hi_s;
                  carry_d = alu_c_s;
                  ovf_d   = alu_v_s;
                  dbz_d   = alu_dbz_s;
                  zero_d  = (alu_res_s == '0) && (alu_hi_s == '0);
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            work_d = (opc_q == OP_MUL) ? mul_next_s : div_next_s;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
               cnt_d   = '0;
               res_d   = work_d[W-1:0];
               hi_d    = work_d[2*W-1:W];
               carry_d = 1'b0;
               dbz_d   = 1'b0;
               ovf_d   = (opc_q == OP_MUL) && (work_d[2*W-1:W] != '0);
               zero_d  = (work_d == '0);
               state_d = S_DONE;
            end else begin
               state_d = S_CALC;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         op2_q   <= '0;
         opc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         hi_q    <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         op2_q   <= op2_d;
         opc_q   <= opc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign result     = res_q;
   assign resultHigh = hi_q;
   assign carryOut   = carry_q;
   assign zero       = zero_q;
   assign overflow   = ovf_q;
   assign divByZero  = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- scoreboard bench for alu_seq (DATA_WIDTH=8, SEL_WIDTH=4).
// Stimulus pushes arithmetic-model expectations; a monitor pops on done.
// ---------------------------------------------------------------------------
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] operand1 = 8'd0;
   logic [7:0] operand2 = 8'd0;
   logic [3:0] opCode = 4'd0;
   logic       busy, done, carryOut, zero, overflow, divByZero;
   logic [7:0] result, resultHigh;

   alu_seq #(.DATA_WIDTH(8), .SEL_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .start(start),
      .operand1(operand1), .operand2(operand2), .opCode(opCode),
      .busy(busy), .done(done), .result(result), .resultHigh(resultHigh),
      .carryOut(carryOut), .zero(zero), .overflow(overflow), .divByZero(divByZero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int res; int hi; int c; int z; int v; int d; int cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation definitions.
   function automatic exp_t model(input int op, input int a, input int b);
      exp_t e;
      int sa, sb, s, n, p;
      e = '{default: 0};
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      n  = b % 8;
      case (op)
         0: begin s = a + b; e.res = s % 256; e.c = (s > 255);
                  e.v = ((sa + sb) > 127) || ((sa + sb) < -128); end
         1: begin e.res = (a - b + 256) % 256; e.c = (a < b);
                  e.v = ((sa - sb) > 127) || ((sa - sb) < -128); end
         2: e.res = a & b;
         3: e.res = a | b;
         4: e.res = a ^ b;
         5: e.res = 255 - a;
         6: begin e.res = (a << n) % 256; e.c = (n == 0) ? 0 : ((a >> (8 - n)) & 1); end
         7: begin e.res = a >> n;         e.c = (n == 0) ? 0 : ((a >> (n - 1)) & 1); end
         8: begin e.res = (sa >>> n) & 255; e.c = (n == 0) ? 0 : ((a >> (n - 1)) & 1); end
         9: begin p = a * b; e.res = p % 256; e.hi = p / 256; e.v = (e.hi != 0); end
         10: begin
            if (b == 0) begin e.res = 255; e.hi = a; e.d = 1; end
            else begin e.res = a / b; e.hi = a % b; end
         end
         default: e.res = 0;
      endcase
      e.z = (e.res == 0) && (e.hi == 0);
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pulse at cycle %0d", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check("done_cycle", cyc, mon_e.cyc);
            check("result", int'(result), mon_e.res);
            check("resultHigh", int'(resultHigh), mon_e.hi);
            check("carryOut", int'(carryOut), mon_e.c);
            check("zero", int'(zero), mon_e.z);
            check("overflow", int'(overflow), mon_e.v);
            check("divByZero", int'(divByZero), mon_e.d);
         end
      end
   end

   // Issue one op at the next accepting edge; returns just after the following negedge.
   task automatic do_op(input int op, input int a, input int b);
      exp_t e;
      for (int k = 0; k < 40 && busy; k++) begin
         @(negedge clk); #1;
      end
      check("idle_before_start", int'(busy), 0);
      e = model(op, a, b);
      e.cyc = cyc + (((op == 9) || ((op == 10) && (b != 0))) ? 9 : 1);
      sb_q.push_back(e);
      opCode = 4'(op); operand1 = 8'(a); operand2 = 8'(b); start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 40; k++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk); #1;
      end
      check("scoreboard_drained", sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_result"}, int'(result), 0);
      check({tag, "_resultHigh"}, int'(resultHigh), 0);
      check({tag, "_flags"}, int'({carryOut, zero, overflow, divByZero}), 0);
   endtask

   int d_op[13] = '{0,   1,   1,   2,   3,   4,   5,   8,   6,   7,   10,  10,  12};
   int d_a [13] = '{255, 128, 1,   240, 240, 170, 90,  129, 3,   129, 200, 85,  77};
   int d_b [13] = '{1,   1,   2,   60,  15,  255, 0,   1,   9,   0,   7,   0,   99};

   initial begin
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;

      // Directed vectors, issued back to back.
      for (int i = 0; i < 13; i++) do_op(d_op[i], d_a[i], d_b[i]);
      wait_idle();

      // MUL 0xFF*0xFF with start pulsed during CALC; busy must stay high.
      do_op(9, 255, 255);
      for (int i = 0; i < 8; i++) begin
         check("busy_in_calc", int'(busy), 1);
         opCode = 4'd0; operand1 = 8'd1; operand2 = 8'd1; start = 1'b1;
         @(negedge clk); #1;
         start = 1'b0;
      end
      wait_idle();

      // Randomized ops, mostly back to back.
      for (int i = 0; i < 80; i++) begin
         int op, a, b;
         op = int'($urandom_range(0, 15));
         a  = int'($urandom_range(0, 255));
         b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
         do_op(op, a, b);
      end
      wait_idle();

      // Reset in CALC cycle 4 of a MUL abandons it; a fresh ADD follows.
      do_op(0, 5, 3);
      wait_idle();
      do_op(9, 171, 3);
      repeat (3) begin @(negedge clk); #1; end
      reset = 1'b1;
      #1;
      check_all_zero("reset_in_calc");
      sb_q.delete();
      @(negedge clk); #1;
      reset = 1'b0;
      do_op(0, 18, 52);
      wait_idle();
      repeat (12) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
